// File: rtl/trail_writer.sv
// rtl/trail_writer.sv - per-frame bike trail painter and optional background sweep for the packed 4bpp frameRAM
// Optional clear sweep is compiled in with `define TRAIL_WRITER_CLEAR_EN.
module trail_writer #(
    parameter logic [3:0] BG_COLOR = 4'h0,
    parameter int         H_RES    = 640,
    parameter int         V_RES    = 480
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        frame_clk,
    input  logic [9:0]  bike0_x,
    input  logic [9:0]  bike0_y,
    input  logic [3:0]  bike0_color,
    input  logic [9:0]  bike1_x,
    input  logic [9:0]  bike1_y,
    input  logic [3:0]  bike1_color,
    input  logic        clear_req,
    output logic [18:0] write_address,
    output logic [15:0] data_In,
    output logic        WE,
    output logic        busy,
    output logic        clear_done
);

    localparam int          WPR   = H_RES / 2;
    localparam int          TOTAL = WPR * V_RES;
    localparam logic [18:0] WPR19 = 19'(WPR);
    localparam logic [10:0] H_LIM = 11'(H_RES);
    localparam logic [10:0] V_LIM = 11'(V_RES);

    if (TOTAL > (1 << 19)) begin : g_addr_overflow
        $error("trail_writer: frame buffer does not fit a 19-bit word address");
    end

    typedef enum logic [1:0] {S_IDLE, S_PAINT, S_CLEAR} state_t;

    state_t      state_q, state_d;
    logic [1:0]  beat_q, beat_d;
    logic [23:0] b0_q, b0_d, b1_q, b1_d;
    logic [18:0] addr_q, addr_d;
    logic [15:0] data_q, data_d;
    logic        we_q, we_d;
    logic        busy_q, busy_d;
    logic        sync1_q, sync2_q, prev_q;
    logic        frame_edge;

    logic [23:0] sel;
    logic [9:0]  sel_x;
    logic [10:0] row;
    logic        in_range;
    logic        emit;

`ifdef TRAIL_WRITER_CLEAR_EN
    localparam logic [19:0] TOTAL20 = 20'(TOTAL);
    localparam logic [15:0] BG_DATA = {8'h00, BG_COLOR, BG_COLOR};
    logic        pend_q, pend_d;
    logic [19:0] cnt_q, cnt_d;
    logic        done_q, done_d;
`else
    logic unused_clear_req;
    assign unused_clear_req = clear_req;
`endif

    assign frame_edge = sync2_q & ~prev_q;

    // In IDLE the first beat is built straight from the live inputs so it can
    // appear the cycle after the edge; later beats use the latched copies.
    always_comb begin
        if (state_q == S_IDLE) begin
            sel = {bike0_x, bike0_y, bike0_color};
        end else if (beat_q[1]) begin
            sel = b1_q;
        end else begin
            sel = b0_q;
        end
    end

    assign sel_x    = sel[23:14];
    assign row      = {1'b0, sel[13:4]} + {10'd0, (state_q != S_IDLE) & beat_q[0]};
    assign in_range = ({1'b0, sel_x} < H_LIM) && (row < V_LIM);

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        b0_d    = b0_q;
        b1_d    = b1_q;
        addr_d  = addr_q;
        data_d  = data_q;
        we_d    = 1'b0;
        busy_d  = 1'b0;
        emit    = 1'b0;
`ifdef TRAIL_WRITER_CLEAR_EN
        pend_d  = pend_q | clear_req;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
`endif
        case (state_q)
            S_IDLE: begin
`ifdef TRAIL_WRITER_CLEAR_EN
                if (pend_q) begin
                    state_d = S_CLEAR;
                    pend_d  = 1'b0;
                    cnt_d   = 20'd1;
                    addr_d  = 19'd0;
                    data_d  = BG_DATA;
                    we_d    = 1'b1;
                    busy_d  = 1'b1;
                end else if (frame_edge && !clear_req) begin
`else
                if (frame_edge) begin
`endif
                    state_d = S_PAINT;
                    beat_d  = 2'd1;
                    b0_d    = {bike0_x, bike0_y, bike0_color};
                    b1_d    = {bike1_x, bike1_y, bike1_color};
                    busy_d  = 1'b1;
                    emit    = 1'b1;
                end
            end
            S_PAINT: begin
                busy_d = 1'b1;
                emit   = 1'b1;
                beat_d = beat_q + 2'd1;
                if (beat_q == 2'd3) begin
                    state_d = S_IDLE;
                end
            end
`ifdef TRAIL_WRITER_CLEAR_EN
            S_CLEAR: begin
                if (cnt_q == TOTAL20) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    addr_d = cnt_q[18:0];
                    data_d = BG_DATA;
                    we_d   = 1'b1;
                    busy_d = 1'b1;
                    cnt_d  = cnt_q + 20'd1;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase

        // Out-of-range beats still take their cycle but leave the bus untouched.
        if (emit && in_range) begin
            we_d   = 1'b1;
            addr_d = 19'(sel_x >> 1) + 19'(row) * WPR19;
            data_d = {8'h00, sel[3:0], sel[3:0]};
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= S_IDLE;
            beat_q  <= 2'd0;
            b0_q    <= 24'd0;
            b1_q    <= 24'd0;
            addr_q  <= 19'd0;
            data_q  <= 16'd0;
            we_q    <= 1'b0;
            busy_q  <= 1'b0;
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            b0_q    <= b0_d;
            b1_q    <= b1_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            we_q    <= we_d;
            busy_q  <= busy_d;
            sync1_q <= frame_clk;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

`ifdef TRAIL_WRITER_CLEAR_EN
    always_ff @(posedge Clk) begin
        if (Reset) begin
            pend_q <= 1'b0;
            cnt_q  <= 20'd0;
            done_q <= 1'b0;
        end else begin
            pend_q <= pend_d;
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end
    assign clear_done = done_q;
`else
    assign clear_done = 1'b0;
`endif

    assign write_address = addr_q;
    assign data_In       = data_q;
    assign WE            = we_q;
    assign busy          = busy_q;

endmodule
